bus_responder: RTL

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bus_responder.sv
// Two-initiator bus responder: round-robin grant, captured single-word
// access to a local word memory, timed completion with error reporting.
module bus_responder #(
   parameter int MEM_WORDS     = 256,
   parameter int WAIT_CYCLES   = 2,
   parameter int GRANT_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  bus_req,
   input  logic [1:0]  bus_use,
   output logic [1:0]  bus_available,
   input  logic [13:0] bus_address,
   input  logic [7:0]  bus_control,
   input  logic [31:0] bus_datai,
   output logic [31:0] bus_datao,
   output logic        fulfilled,
   output logic        bus_error
);

   // state  | meaning
   // IDLE   | no grant outstanding; arbitrate pending requests
   // GRANT  | grant issued, waiting for the initiator to drive the bus
   // ACCESS | request captured, latency counter running down
   // DONE   | completion strobed, waiting for the initiator to release
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_ACCESS,
      ST_DONE
   } state_t;

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [31:0] mem [MEM_WORDS];

   state_t      state_q, state_d;
   logic [1:0]  avail_q, avail_d;
   logic        last_q, last_d;
   logic        gnt_q, gnt_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [13:0] addr_q, addr_d;
   logic [7:0]  ctl_q, ctl_d;
   logic [31:0] data_q, data_d;
   logic [31:0] datao_q, datao_d;
   logic        ful_q, ful_d;
   logic        err_q, err_d;

   logic          mem_we;
   logic          use_g;
   logic          addr_ok;
   logic          win;
   logic [AW-1:0] mem_idx;

   assign use_g   = bus_use[gnt_q];
   assign addr_ok = ({18'd0, addr_q} < 32'(MEM_WORDS));
   assign mem_idx = AW'(addr_q);

   assign bus_available = avail_q;
   assign bus_datao     = datao_q;
   assign fulfilled     = ful_q;
   assign bus_error     = err_q;

   // State and datapath registers; memory is intentionally not reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         avail_q <= 2'b00;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         wcnt_q  <= 4'd0;
         tcnt_q  <= 16'd0;
         addr_q  <= 14'd0;
         ctl_q   <= 8'd0;
         data_q  <= 32'd0;
         datao_q <= 32'd0;
         ful_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         avail_q <= avail_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         wcnt_q  <= wcnt_d;
         tcnt_q  <= tcnt_d;
         addr_q  <= addr_d;
         ctl_q   <= ctl_d;
         data_q  <= data_d;
         datao_q <= datao_d;
         ful_q   <= ful_d;
         err_q   <= err_d;
      end
   end

   // Memory write port, enabled only on a legal write completion.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[mem_idx] <= data_q;
      end
   end

   // Next-state logic: arbitration, capture, latency and timeout timers.
   always_comb begin
      state_d = state_q;
      avail_d = avail_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      wcnt_d  = wcnt_q;
      tcnt_d  = tcnt_q;
      addr_d  = addr_q;
      ctl_d   = ctl_q;
      data_d  = data_q;
      datao_d = datao_q;
      ful_d   = 1'b0;
      err_d   = 1'b0;
      mem_we  = 1'b0;
      win     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|bus_req) begin
               // On a tie the initiator not granted last wins.
               win     = (bus_req == 2'b11) ? ~last_q : bus_req[1];
               gnt_d   = win;
               avail_d = win ? 2'b10 : 2'b01;
               tcnt_d  = 16'(GRANT_TIMEOUT - 1);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (use_g) begin
               addr_d  = bus_address;
               ctl_d   = bus_control;
               data_d  = bus_datai;
               wcnt_d  = 4'(WAIT_CYCLES);
               state_d = ST_ACCESS;
            end else if (tcnt_q == 16'd0) begin
               avail_d = 2'b00;
               last_d  = gnt_q;
               state_d = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q - 16'd1;
            end
         end
         ST_ACCESS: begin
            if (!use_g) begin
               // Initiator walked away: drop the transfer silently.
               avail_d = 2'b00;
               last_d  = gnt_q;
               state_d = ST_IDLE;
            end else if (wcnt_q == 4'd0) begin
               ful_d   = 1'b1;
               state_d = ST_DONE;
               if (!addr_ok || (ctl_q > 8'h01)) begin
                  err_d   = 1'b1;
                  datao_d = 32'd0;
               end else if (ctl_q == 8'h00) begin
                  datao_d = mem[mem_idx];
               end else begin
                  mem_we  = 1'b1;
                  datao_d = 32'd0;
               end
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (!use_g) begin
               avail_d = 2'b00;
               last_d  = gnt_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
